// File: rtl/cam_pixel_assembler.sv
// Assembles OV7670 RGB565 byte pairs into RGB444 pixels tagged with frame coordinates.
// Latency: pixel outputs are registered one clk after the low byte lands in the input register.
// Backpressure: none; the camera cannot be stalled, so pixels outside the active window are dropped and flagged.
module cam_pixel_assembler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pixel_valid,
  output logic       href_out,
  output logic       vsync_out,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       overrun
);

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    BLANK    = 2'd2
  } state_e;

  // Input registers and their one-cycle history for edge detection
  logic       vsync_q, vsync_d;
  logic       href_q, href_d;
  logic [7:0] data_q, data_d;
  logic       vsync_prev_q, vsync_prev_d;
  logic       href_prev_q, href_prev_d;

  // Frame tracking and byte assembly state
  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  logic [7:0] hi_byte_q, hi_byte_d;
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;

  // Registered outputs
  logic       pixel_valid_q, pixel_valid_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       overrun_q, overrun_d;

  // Edges of the registered syncs; href falling is seen on the first low cycle
  logic vs_rise, vs_fall, href_fall, in_frame, x_in_win, y_in_win;
  assign vs_rise   = vsync_q & ~vsync_prev_q;
  assign vs_fall   = ~vsync_q & vsync_prev_q;
  assign href_fall = ~href_q & href_prev_q;
  assign in_frame  = (state_q == ACTIVE) && !vsync_q;
  assign x_in_win  = (x_cnt_q < H_MAX);
  assign y_in_win  = (y_cnt_q < V_MAX);

  // Next-state logic: input capture, frame FSM, byte pairing, counters and status
  always_comb begin
    vsync_d       = vsync;
    href_d        = href;
    data_d        = data;
    vsync_prev_d  = vsync_q;
    href_prev_d   = href_q;
    state_d       = state_q;
    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    // Frame-level state: nothing is trusted until the first end of blanking
    case (state_q)
      WAIT_SOF: if (vs_fall) state_d = ACTIVE;
      ACTIVE:   if (vs_rise) state_d = BLANK;
      BLANK:    if (vs_fall) state_d = ACTIVE;
      default:  state_d = WAIT_SOF;
    endcase

    // The very first vsync fall only synchronises us, so it does not count as a frame
    if (vs_fall) begin
      frame_done_d = 1'b1;
      if (state_q != WAIT_SOF) frame_count_d = frame_count_q + 8'd1;
    end

    if (vs_rise) begin
      // Start of frame has priority over a coincident end of line
      x_cnt_d   = '0;
      y_cnt_d   = '0;
      phase_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (href_q && vsync_q) begin
      // Bytes during vertical blanking are junk; keep pairing aligned for the next line
      phase_d = 1'b0;
    end else if (in_frame) begin
      if (href_fall) begin
        // A dangling high byte is simply forgotten by clearing the phase
        x_cnt_d = '0;
        phase_d = 1'b0;
        if (x_cnt_q != 10'd0 && y_in_win) y_cnt_d = y_cnt_q + 10'd1;
      end else if (href_q) begin
        if (!phase_q) begin
          hi_byte_d = data_q;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (x_in_win && y_in_win) begin
            // RGB565 -> RGB444 by dropping the LSBs of each channel
            pixel_valid_d = 1'b1;
            pixel_x_d     = x_cnt_q;
            pixel_y_d     = y_cnt_q;
            r_d           = hi_byte_q[7:4];
            g_d           = {hi_byte_q[2:0], data_q[7]};
            b_d           = data_q[4:1];
          end else begin
            overrun_d = 1'b1;
          end
          if (x_in_win) x_cnt_d = x_cnt_q + 10'd1;
        end
      end
    end
  end

  // All state flops; asynchronous reset returns to waiting for start of frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
      vsync_prev_q  <= 1'b0;
      href_prev_q   <= 1'b0;
      state_q       <= WAIT_SOF;
      phase_q       <= 1'b0;
      hi_byte_q     <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      vsync_prev_q  <= vsync_prev_d;
      href_prev_q   <= href_prev_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  // vsync_prev_q is vsync two clocks late, which keeps vsync_out aligned with frame_done
  assign pixel_valid = pixel_valid_q;
  assign href_out    = pixel_valid_q;
  assign vsync_out   = vsync_prev_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Bench for cam_pixel_assembler: directed byte streams feed a pixel scoreboard.
// A negedge monitor pops one expected pixel per strobe; status outputs are checked inline.
// Uses a reduced 8x4 active window so full frames stay short.
module tb_cam_pixel_assembler;

  localparam int H = 8;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] data = 8'h00;
  logic       pixel_valid, href_out, vsync_out, frame_done, overrun;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] r_out, g_out, b_out;
  logic [7:0] frame_count;

  cam_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .data(data),
    .pixel_valid(pixel_valid), .href_out(href_out), .vsync_out(vsync_out),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } px_t;

  px_t  exp_q[$];
  px_t  exp_px;
  int   checks = 0;
  int   errors = 0;
  logic pv_prev = 1'b0;

  // RGB565 high/low byte -> expected RGB444 with coordinates
  function automatic px_t mk(int x, int y, logic [7:0] hi, logic [7:0] lo);
    px_t p;
    p.x = 10'(x);
    p.y = 10'(y);
    p.r = hi[7:4];
    p.g = {hi[2:0], lo[7]};
    p.b = lo[4:1];
    return p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected pixel
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) begin
        chk("href_out_eq_valid", 64'(href_out), 64'd1);
        chk("valid_not_back_to_back", 64'(pv_prev), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=%h%h%h, expected no strobe",
                   pixel_x, pixel_y, r_out, g_out, b_out);
        end else begin
          exp_px = exp_q.pop_front();
          chk("pixel", 64'({pixel_x, pixel_y, r_out, g_out, b_out}), 64'(exp_px));
        end
      end
    end
    pv_prev = pixel_valid;
  end

  task automatic cyc(logic v, logic h, logic [7:0] d);
    @(negedge clk);
    vsync = v;
    href  = h;
    data  = d;
  endtask

  task automatic bt(logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic px(int x, int y, logic [7:0] hi, logic [7:0] lo, bit expect_out);
    bt(hi);
    bt(lo);
    if (expect_out) exp_q.push_back(mk(x, y, hi, lo));
  endtask

  task automatic vs_high(int n);
    repeat (n) cyc(1'b1, 1'b0, 8'h00);
  endtask

  // Drop vsync (assumed high for >=2 cycles) and check frame_done / vsync_out timing
  task automatic vs_fall(int exp_count);
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("frame_done_not_early", 64'(frame_done), 64'd0);
    chk("vsync_out_still_high", 64'(vsync_out), 64'd1);
    @(negedge clk);
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("vsync_out_fell", 64'(vsync_out), 64'd0);
    chk("frame_count", 64'(frame_count), 64'(exp_count));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({pixel_valid, href_out, vsync_out, frame_done, overrun, frame_count,
                pixel_x, pixel_y, r_out, g_out, b_out});
  endfunction

  initial begin
    int b;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;

    // Pre-sync traffic must produce nothing
    for (int i = 0; i < 16; i++) cyc(1'b0, (i % 4) < 2, 8'(i * 17));
    vs_high(3);
    vs_fall(0);
    idle(2);

    // Line 0: single hand-computed pixel with exact latency
    bt(8'hF8);
    bt(8'h1F);
    exp_q.push_back(mk(0, 0, 8'hF8, 8'h1F));
    @(negedge clk);
    chk("latency_not_early", 64'(pixel_valid), 64'd0);
    href = 1'b0;
    @(negedge clk);
    chk("single_pixel", 64'({pixel_valid, pixel_x, pixel_y, r_out, g_out, b_out}),
        64'({1'b1, 10'd0, 10'd0, 4'd15, 4'd0, 4'd15}));
    idle(2);

    // A line with one lone byte does not advance the row
    bt(8'h77);
    idle(2);

    // Line 1: odd byte count, trailing 0xAA discarded
    px(0, 1, 8'hFF, 8'hFF, 1'b1);
    bt(8'hAA);
    idle(2);
    chk("overrun_clear_before_long", 64'(overrun), 64'd0);

    // Line 2: ten pixels into an eight-wide window
    for (int k = 0; k < 10; k++) px(k, 2, 8'(k * 37 + 5), 8'(k * 59 + 13), k < H);
    idle(1);
    chk("overrun_long_line", 64'(overrun), 64'd1);
    idle(1);

    // Line 3: column restarts at 0, pairing intact after the odd line
    px(0, 3, 8'hAB, 8'hCD, 1'b1);
    px(1, 3, 8'h12, 8'h34, 1'b1);
    idle(2);

    // Line 4 exceeds the window height: no strobes
    px(0, 4, 8'h55, 8'h66, 1'b0);
    px(1, 4, 8'h77, 8'h88, 1'b0);
    idle(2);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Vertical blanking with href bytes that must be ignored
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b1, 8'h33);
    vs_high(2);
    chk("overrun_cleared_sof", 64'(overrun), 64'd0);
    vs_fall(1);
    idle(2);
    px(0, 0, 8'h12, 8'h34, 1'b1);
    idle(2);

    // Full reduced frame with incrementing data
    vs_high(3);
    vs_fall(2);
    idle(2);
    b = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        px(x, y, 8'(b), 8'(b + 1), 1'b1);
        b += 2;
      end
      idle(2);
    end
    chk("last_pixel_xy", 64'({pixel_x, pixel_y}), 64'({10'(H - 1), 10'(V - 1)}));
    chk("overrun_full_frame", 64'(overrun), 64'd0);
    vs_high(3);
    vs_fall(3);
    idle(1);

    // Asynchronous reset in the middle of a line
    bt(8'h99);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    href  = 1'b0;
    px(0, 0, 8'h44, 8'h55, 1'b0);
    idle(2);
    vs_high(3);
    vs_fall(0);

    // 256 short frames wrap the frame counter
    for (int f = 1; f <= 256; f++) begin
      vs_high(2);
      idle(3);
      if (f == 255) chk("frame_count_255", 64'(frame_count), 64'd255);
    end
    chk("frame_count_wrap", 64'(frame_count), 64'd0);

    idle(5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
